fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined CPU. It tracks in-flight register writers internally in a shift scoreboard instead of taking per-stage destination inputs, so the core no longer routes per-stage destination IDs to it. Each cycle it resolves, for the instruction in ID, a forwarding source for every operand and a load-use (or any late-result) stall. Selects are registered, so they arrive with the instruction as it enters EX.

---
 rtl/fwd_pkg.sv | 27 ++
 rtl/fwd_match.sv | 53 +++++
 rtl/fwd_scoreboard.sv | 123 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared types and constants for the forwarding / hazard scoreboard.
//   sb_entry_t : one scoreboard slot {valid, wr, rd, res_stage}.
//   STG_EX     : scoreboard index of the EX stage.
//   STG_MEM    : scoreboard index of the MEM stage.
//   FWD_RF     : forward select meaning "use the register file".
// The rd and res_stage fields are sized for the largest configuration in use.
// Narrower register IDs and stage indices are zero-extended into them.
// ---------------------------------------------------------------------------
package fwd_pkg;

    localparam int SB_RD_W  = 8;   // holds register IDs for up to 256 registers
    localparam int SB_STG_W = 4;   // holds stage indices for up to 16 stages

    typedef struct packed {
        logic                valid;
        logic                wr;
        logic [SB_RD_W-1:0]  rd;
        logic [SB_STG_W-1:0] res_stage;
    } sb_entry_t;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int FWD_RF  = 0;

endpackage

// File: rtl/fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// Youngest-producer search for one source operand.
// Only the entries that can still forward are passed in, which is every
// stage except WB. WB is covered by the register-file write bypass.
// Ports:
//   cand   in   scoreboard entries 0..STAGES-2 (index 0 = youngest)
//   src    in   source register ID
//   used   in   operand is actually read
//   hit    out  a qualifying producer exists
//   stall  out  the youngest producer's result is not ready yet
//   sel    out  forward select (stage the producer occupies next cycle)
// ---------------------------------------------------------------------------
module fwd_match
    import fwd_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_W  = 4,
    parameter int SEL_W  = 2
) (
    input  sb_entry_t        cand [STAGES-1],
    input  logic [REG_W-1:0] src,
    input  logic             used,
    output logic             hit,
    output logic             stall,
    output logic [SEL_W-1:0] sel
);

    // Scan from the oldest candidate down to the youngest, so the youngest
    // matching producer is the last one assigned.
    always_comb begin
        hit   = 1'b0;
        stall = 1'b0;
        sel   = SEL_W'(FWD_RF);
        if (used && (src != '0)) begin
            for (int k = STAGES - 2; k >= 0; k--) begin
                if (cand[k].valid && cand[k].wr && (cand[k].rd == SB_RD_W'(src))) begin
                    hit = 1'b1;
                    // The producer sits in stage k+1 when the consumer reaches EX.
                    // Its result exists only once that stage is past res_stage.
                    if ((k + 1) > int'(cand[k].res_stage)) begin
                        stall = 1'b0;
                        sel   = SEL_W'(k + 1);
                    end else begin
                        stall = 1'b1;
                        sel   = SEL_W'(FWD_RF);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
// Forwarding and hazard unit with an internal shift scoreboard of in-flight
// register writers. It resolves forward selects and late-result stalls for
// the instruction in ID. Selects are registered so they arrive with the
// instruction in EX.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   id_valid      ID holds a real instruction
//   id_wr         ID instruction writes a register
//   id_rd         ID destination register
//   id_res_stage  stage at whose end the result exists (0 ALU, 1 load)
//   id_src        packed source register IDs, operand i in slice i
//   id_src_used   per-operand read flags
//   freeze        global pipeline hold
//   flush         kill instructions in ID and EX
//   hazard_stall  combinational stall request (hold IF/ID, EX bubble)
//   ex_valid      EX holds a real instruction
//   ex_fwd_sel    registered per-operand forward select
// ---------------------------------------------------------------------------
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int NUM_SRC  = 2,
    parameter int STAGES   = 3,
    parameter int REG_W    = $clog2(NUM_REGS),
    parameter int SEL_W    = $clog2(STAGES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic                     id_wr,
    input  logic [REG_W-1:0]         id_rd,
    input  logic [SEL_W-1:0]         id_res_stage,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic                     freeze,
    input  logic                     flush,
    output logic                     hazard_stall,
    output logic                     ex_valid,
    output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel
);

    sb_entry_t                  sb_p [STAGES];
    sb_entry_t                  cand [STAGES-1];
    logic [NUM_SRC*SEL_W-1:0]   sel_p0;

    logic [NUM_SRC-1:0]         op_hit;
    logic [NUM_SRC-1:0]         op_stall;
    logic [SEL_W-1:0]           op_sel [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0]   sel_vec;
    sb_entry_t                  id_entry;
    logic                       issue;

    // WB is not a forwarding candidate, so only entries 0..STAGES-2 are searched.
    always_comb begin
        for (int k = 0; k < STAGES - 1; k++) begin
            cand[k] = sb_p[k];
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        fwd_match #(
            .STAGES (STAGES),
            .REG_W  (REG_W),
            .SEL_W  (SEL_W)
        ) u_match (
            .cand  (cand),
            .src   (id_src[i*REG_W +: REG_W]),
            .used  (id_src_used[i]),
            .hit   (op_hit[i]),
            .stall (op_stall[i]),
            .sel   (op_sel[i])
        );
    end

    assign hazard_stall = id_valid & ~flush & (|op_stall);
    assign issue        = id_valid & ~hazard_stall & ~flush;

    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_vec[i*SEL_W +: SEL_W] = op_hit[i] ? op_sel[i] : SEL_W'(FWD_RF);
        end
    end

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = 1'b1;
        id_entry.wr        = id_wr;
        id_entry.rd        = SB_RD_W'(id_rd);
        id_entry.res_stage = SB_STG_W'(id_res_stage);
    end

    // ID -> EX boundary: scoreboard shift and registered selects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                sb_p[k] <= '0;
            end
            sel_p0 <= '0;
        end else if (!freeze) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                sb_p[k] <= sb_p[k-1];
            end
            // The instruction in EX is killed, so it must not reach MEM.
            if (flush) begin
                sb_p[STG_MEM] <= '0;
            end
            sb_p[STG_EX] <= issue ? id_entry : '0;
            sel_p0       <= issue ? sel_vec : '0;
        end else if (flush) begin
            // Frozen flush kills only EX; older stages keep their contents.
            sb_p[STG_EX] <= '0;
            sel_p0       <= '0;
        end
    end

    assign ex_valid   = sb_p[STG_EX].valid;
    assign ex_fwd_sel = sel_p0;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic       id_wr;
    logic [3:0] id_rd;
    logic [1:0] id_res_stage;
    logic [7:0] id_src;
    logic [1:0] id_src_used;
    logic       freeze;
    logic       flush;
    logic       hazard_stall;
    logic       ex_valid;
    logic [3:0] ex_fwd_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fwd_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_wr        (id_wr),
        .id_rd        (id_rd),
        .id_res_stage (id_res_stage),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .freeze       (freeze),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .ex_valid     (ex_valid),
        .ex_fwd_sel   (ex_fwd_sel)
    );

    typedef struct {
        logic       v;
        logic       wr;
        logic [3:0] rd;
        logic [1:0] rs;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [1:0] used;
        logic       frz;
        logic       fl;
        logic       st;
        logic       ev;
        logic [1:0] e0;
        logic [1:0] e1;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic wr, input int rd, input int rs,
                                input int s0, input int s1, input int used,
                                input logic frz, input logic fl,
                                input logic st, input logic ev, input int e0, input int e1);
        vec_t t;
        t.v = v;  t.wr = wr;  t.rd = 4'(rd);  t.rs = 2'(rs);
        t.s0 = 4'(s0);  t.s1 = 4'(s1);  t.used = 2'(used);
        t.frz = frz;  t.fl = fl;
        t.st = st;  t.ev = ev;  t.e0 = 2'(e0);  t.e1 = 2'(e1);
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid     = t.v;
        id_wr        = t.wr;
        id_rd        = t.rd;
        id_res_stage = t.rs;
        id_src       = {t.s1, t.s0};
        id_src_used  = t.used;
        freeze       = t.frz;
        flush        = t.fl;
    endtask

    // One ID cycle: stall checked mid-cycle, EX outputs checked after the edge.
    task automatic step(input vec_t t, input string nm);
        @(negedge clk);
        drive(t);
        #1;
        chk({nm, ".stall"}, int'(hazard_stall), int'(t.st));
        @(posedge clk);
        #1;
        chk({nm, ".ex_valid"}, int'(ex_valid), int'(t.ev));
        chk({nm, ".sel0"}, int'(ex_fwd_sel[1:0]), int'(t.e0));
        chk({nm, ".sel1"}, int'(ex_fwd_sel[3:2]), int'(t.e1));
    endtask

    vec_t tbl [15];

    initial begin
        // args: v wr rd rs s0 s1 used frz fl | st ev sel0 sel1
        tbl[0]  = mk(1, 1, 3, 0, 1, 2, 3, 0, 0,  0, 1, 0, 0); // r3 ALU producer
        tbl[1]  = mk(1, 0, 0, 0, 3, 0, 1, 0, 0,  0, 1, 1, 0); // back-to-back -> 1
        tbl[2]  = mk(1, 1, 7, 0, 3, 0, 1, 0, 0,  0, 1, 2, 0); // distance 2 -> 2, writes r7
        tbl[3]  = mk(1, 0, 0, 0, 3, 7, 3, 0, 0,  0, 1, 0, 1); // r3 dist 3 -> 0, r7 -> 1
        tbl[4]  = mk(1, 1, 4, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0); // r4 older writer
        tbl[5]  = mk(1, 1, 4, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0); // r4 younger writer
        tbl[6]  = mk(1, 0, 0, 0, 4, 4, 3, 0, 0,  0, 1, 1, 1); // youngest wins
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0); // writer of r0
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0); // read r0 -> no forward
        tbl[9]  = mk(1, 1, 9, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0); // r9 producer
        tbl[10] = mk(1, 0, 0, 0, 9, 0, 2, 0, 0,  0, 1, 0, 0); // r9 present but unused
        tbl[11] = mk(1, 1, 5, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0); // load r5
        tbl[12] = mk(1, 0, 0, 0, 0, 5, 2, 0, 0,  1, 0, 0, 0); // load-use stall, bubble
        tbl[13] = mk(1, 0, 0, 0, 0, 5, 2, 0, 0,  0, 1, 0, 2); // consumer issues with 2
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0); // idle

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.stall", int'(hazard_stall), 0);
        chk("reset.ex_valid", int'(ex_valid), 0);
        chk("reset.sel", int'(ex_fwd_sel), 0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Flush during a load-use stall: the load is killed and never forwards.
        step(mk(1, 1, 5, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0), "fl.load");
        step(mk(1, 0, 0, 0, 0, 5, 2, 0, 1,  0, 0, 0, 0), "fl.flush");
        step(mk(1, 0, 0, 0, 0, 5, 2, 0, 0,  0, 1, 0, 0), "fl.after");

        // Freeze holds the selects and the scoreboard for three cycles.
        step(mk(1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0), "fz.prod");
        step(mk(1, 0, 0, 0, 8, 0, 1, 0, 0,  0, 1, 1, 0), "fz.cons");
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 1, 9, 0, 8, 0, 1, 1, 0,  0, 1, 1, 0), $sformatf("fz.hold%0d", i));
        end
        step(mk(1, 1, 10, 0, 8, 0, 1, 0, 0,  0, 1, 2, 0), "fz.release");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0), "fz.filler");
        // Flush while frozen clears EX only; r10 stays in MEM.
        step(mk(1, 1, 1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0), "fz.flush");
        step(mk(1, 0, 0, 0, 10, 0, 1, 0, 0,  0, 1, 2, 0), "fz.kept");
        // Stall is still evaluated under freeze.
        step(mk(1, 1, 13, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0), "fz.load");
        step(mk(1, 0, 0, 0, 13, 0, 1, 1, 0,  1, 1, 0, 0), "fz.stall_frz");
        step(mk(1, 0, 0, 0, 13, 0, 1, 0, 0,  1, 0, 0, 0), "fz.stall");
        step(mk(1, 0, 0, 0, 13, 0, 1, 0, 0,  0, 1, 2, 0), "fz.issue");

        // Reset mid-pipeline clears outputs without waiting for an edge.
        step(mk(1, 1, 11, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0), "rs.prod");
        step(mk(1, 1, 12, 1, 11, 0, 1, 0, 0,  0, 1, 1, 0), "rs.load");
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 12, 0, 1, 0, 0,  0, 0, 0, 0));
        #1;
        chk("rs.pre_stall", int'(hazard_stall), 1);
        rst = 1'b1;
        #1;
        chk("rs.stall", int'(hazard_stall), 0);
        chk("rs.ex_valid", int'(ex_valid), 0);
        chk("rs.sel", int'(ex_fwd_sel), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rs.post_stall", int'(hazard_stall), 0);
        @(posedge clk);
        #1;
        chk("rs.post_ex_valid", int'(ex_valid), 1);
        chk("rs.post_sel", int'(ex_fwd_sel), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
